// File: rtl/otter_dmem_pkg.sv
// -----------------------------------------------------------------------------
// otter_dmem_pkg
// Shared definitions for the OTTER data-memory controller:
//   - dmem_state_t : controller state encoding (IDLE, RAM_RD, MMIO_WAIT, DONE)
//   - DEF_MMIO_BASE / DEF_MMIO_MASK : default MMIO window decode
//   - BUS_ERR_DATA : read data returned by an aborted MMIO access
//   - STRB_* and strb_legal() : the legal write-strobe shapes and their
//     required alignment (used when OTTER_DMEM_STRB_CHK_EN is defined)
// -----------------------------------------------------------------------------
package otter_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAM_RD    = 2'd1,
    MMIO_WAIT = 2'd2,
    DONE      = 2'd3
  } dmem_state_t;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h1100_0000;
  localparam logic [31:0] DEF_MMIO_MASK = 32'hFF00_0000;
  localparam logic [31:0] BUS_ERR_DATA  = 32'hDEAD_BEEF;

  // Legal strobe shapes: single bytes, aligned halfwords, full word.
  localparam logic [3:0] STRB_B0 = 4'b0001;
  localparam logic [3:0] STRB_B1 = 4'b0010;
  localparam logic [3:0] STRB_B2 = 4'b0100;
  localparam logic [3:0] STRB_B3 = 4'b1000;
  localparam logic [3:0] STRB_H0 = 4'b0011;
  localparam logic [3:0] STRB_H1 = 4'b1100;
  localparam logic [3:0] STRB_W  = 4'b1111;

  // A strobe is legal when it has one of the shapes above and its lowest
  // enabled lane equals the byte offset of the address.
  function automatic logic strb_legal(input logic [3:0] strb, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (strb)
      STRB_B0: ok = (lo == 2'd0);
      STRB_B1: ok = (lo == 2'd1);
      STRB_B2: ok = (lo == 2'd2);
      STRB_B3: ok = (lo == 2'd3);
      STRB_H0: ok = (lo == 2'd0);
      STRB_H1: ok = (lo == 2'd2);
      STRB_W:  ok = (lo == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/otter_dmem_ram.sv
// -----------------------------------------------------------------------------
// otter_dmem_ram
// Single-port synchronous RAM, 2^ADDR_WIDTH words of 32 bits, built as four
// independent byte lanes so each lane maps onto its own block-RAM column.
// Ports:
//   clk     : clock, rising edge
//   we      : per-lane write enables (lane i = bits [8i+7:8i])
//   re      : read enable; read data appears the cycle after re
//   addr    : word address
//   w_data  : write data, lane-aligned
//   r_data  : registered read data
// Contents are never reset.
// -----------------------------------------------------------------------------
module otter_dmem_ram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           w_data,
  output logic [31:0]           r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[addr] <= w_data[gi*8 +: 8];
        end
        if (re) begin
          rd_reg <= mem[addr];
        end
      end

      assign r_data[gi*8 +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/otter_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// otter_dmem_ctrl
// Responder for the OTTER core's data-memory port. RAM accesses go to a
// byte-strobed synchronous RAM (zero-stall writes, one-stall reads); accesses
// inside the MMIO window are forwarded to a req/ack peripheral bus with a
// timeout that aborts with bus_err and BUS_ERR_DATA.
// Optional feature: define OTTER_DMEM_STRB_CHK_EN to reject write strobes
// that are not an aligned byte/halfword/word shape (write dropped, bus_err
// pulsed in the request cycle, no stall).
// Ports:
//   clk, rst                : clock (rising edge), async active-low reset
//   dmem_r_en / dmem_w_en   : read / write request (write wins if both)
//   dmem_w_strb             : lane-shifted byte enables
//   dmem_addr / dmem_w_data : byte address / lane-aligned write data
//   dmem_r_data             : read data, non-zero only in a read response cycle
//   dmem_stall              : core holds its request while high
//   bus_err                 : one-cycle pulse on an aborted access
//   mmio_req/we/strb/addr/w_data : peripheral request, held until mmio_ack
//   mmio_ack / mmio_r_data  : peripheral completion pulse and read data
// -----------------------------------------------------------------------------
module otter_dmem_ctrl
  import otter_dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_MASK  = DEF_MMIO_MASK,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_r_en,
  input  logic        dmem_w_en,
  input  logic [3:0]  dmem_w_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_w_data,
  output logic [31:0] dmem_r_data,
  output logic        dmem_stall,
  output logic        bus_err,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [3:0]  mmio_strb,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_w_data,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_r_data
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  dmem_state_t state_reg;
  logic [7:0]  cnt_reg;
  logic        mmio_req_reg;
  logic        mmio_we_reg;
  logic [3:0]  mmio_strb_reg;
  logic [31:0] mmio_addr_reg;
  logic [31:0] mmio_w_data_reg;
  logic [31:0] rdata_reg;
  logic        bus_err_reg;

  logic        is_mmio;
  logic        is_rd;
  logic        strb_bad;
  logic        in_idle;
  logic        accept_wr;
  logic        ram_re;
  logic        start_mmio;
  logic [3:0]  ram_we;
  logic [31:0] ram_q;

  assign is_mmio = ((dmem_addr & MMIO_MASK) == MMIO_BASE);
  // Write has priority, so a read is only a read when no write is present.
  assign is_rd   = dmem_r_en & ~dmem_w_en;

`ifdef OTTER_DMEM_STRB_CHK_EN
  assign strb_bad = dmem_w_en & ~strb_legal(dmem_w_strb, dmem_addr[1:0]);
`else
  assign strb_bad = 1'b0;
`endif

  // Requests are only accepted in IDLE and never while reset is held, so a
  // request left asserted by the core during reset cannot stall or write.
  assign in_idle    = (state_reg == IDLE) & rst;
  assign accept_wr  = in_idle & dmem_w_en & ~strb_bad;
  assign ram_we     = (accept_wr & ~is_mmio) ? dmem_w_strb : 4'b0000;
  assign ram_re     = in_idle & is_rd & ~is_mmio;
  assign start_mmio = in_idle & is_mmio & (is_rd | accept_wr);

  otter_dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (dmem_addr[ADDR_WIDTH+1:2]),
    .w_data(dmem_w_data),
    .r_data(ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 8'd0;
      mmio_req_reg    <= 1'b0;
      mmio_we_reg     <= 1'b0;
      mmio_strb_reg   <= 4'b0000;
      mmio_addr_reg   <= 32'd0;
      mmio_w_data_reg <= 32'd0;
      rdata_reg       <= 32'd0;
      bus_err_reg     <= 1'b0;
    end else begin
      bus_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_mmio) begin
            mmio_req_reg    <= 1'b1;
            mmio_we_reg     <= dmem_w_en;
            // Reads are whole-word on the peripheral side; no lanes enabled.
            mmio_strb_reg   <= dmem_w_en ? dmem_w_strb : 4'b0000;
            mmio_addr_reg   <= dmem_addr;
            mmio_w_data_reg <= dmem_w_data;
            cnt_reg         <= 8'd0;
            state_reg       <= MMIO_WAIT;
          end else if (ram_re) begin
            state_reg <= RAM_RD;
          end
        end
        RAM_RD: begin
          state_reg <= IDLE;
        end
        MMIO_WAIT: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (mmio_ack) begin
            rdata_reg    <= mmio_r_data;
            cnt_reg      <= 8'd0;
            mmio_req_reg <= 1'b0;
            state_reg    <= DONE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_reg      <= cnt_reg + 8'd1;
            rdata_reg    <= BUS_ERR_DATA;
            mmio_req_reg <= 1'b0;
            bus_err_reg  <= 1'b1;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dmem_r_data = 32'd0;
    if (state_reg == RAM_RD) begin
      dmem_r_data = ram_q;
    end else if ((state_reg == DONE) && !mmio_we_reg) begin
      dmem_r_data = rdata_reg;
    end
  end

  assign dmem_stall  = (state_reg == MMIO_WAIT) | ram_re | start_mmio;
  assign bus_err     = bus_err_reg | (in_idle & strb_bad);
  assign mmio_req    = mmio_req_reg;
  assign mmio_we     = mmio_we_reg;
  assign mmio_strb   = mmio_strb_reg;
  assign mmio_addr   = mmio_addr_reg;
  assign mmio_w_data = mmio_w_data_reg;

endmodule

// File: tb/tb_otter_dmem_ctrl.sv
module tb_otter_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_r_en = 1'b0;
  logic        dmem_w_en = 1'b0;
  logic [3:0]  dmem_w_strb = 4'b0000;
  logic [31:0] dmem_addr = 32'd0;
  logic [31:0] dmem_w_data = 32'd0;
  logic [31:0] dmem_r_data;
  logic        dmem_stall;
  logic        bus_err;
  logic        mmio_req;
  logic        mmio_we;
  logic [3:0]  mmio_strb;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_w_data;
  logic        mmio_ack = 1'b0;
  logic [31:0] mmio_r_data = 32'd0;

  int checks   = 0;
  int failures = 0;
  int n;

`ifdef OTTER_DMEM_STRB_CHK_EN
  localparam logic        EXP_STRB_ERR = 1'b1;
  localparam logic [31:0] EXP_WORD20   = 32'h1122_3344;
`else
  localparam logic        EXP_STRB_ERR = 1'b0;
  localparam logic [31:0] EXP_WORD20   = 32'h11BB_CC44;
`endif

  otter_dmem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_r_en  (dmem_r_en),
    .dmem_w_en  (dmem_w_en),
    .dmem_w_strb(dmem_w_strb),
    .dmem_addr  (dmem_addr),
    .dmem_w_data(dmem_w_data),
    .dmem_r_data(dmem_r_data),
    .dmem_stall (dmem_stall),
    .bus_err    (bus_err),
    .mmio_req   (mmio_req),
    .mmio_we    (mmio_we),
    .mmio_strb  (mmio_strb),
    .mmio_addr  (mmio_addr),
    .mmio_w_data(mmio_w_data),
    .mmio_ack   (mmio_ack),
    .mmio_r_data(mmio_r_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      $display("ok   %-22s observed=0x%08h", tag, obs);
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    dmem_r_en   = r;
    dmem_w_en   = w;
    dmem_w_strb = s;
    dmem_addr   = a;
    dmem_w_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  initial begin
    // Reset: a request held during reset must not produce any output.
    drive(1'b1, 1'b0, 4'b0000, 32'h1100_0000, 32'd0);
    #2;
    check("rst_stall",   {31'd0, dmem_stall}, 32'd0);
    check("rst_rdata",   dmem_r_data, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_req",     {31'd0, mmio_req}, 32'd0);
    check("rst_we",      {31'd0, mmio_we}, 32'd0);
    check("rst_strb",    {28'd0, mmio_strb}, 32'd0);
    check("rst_addr",    mmio_addr, 32'd0);
    check("rst_wdata",   mmio_w_data, 32'd0);
    cyc();
    idle();
    cyc();
    rst = 1'b1;

    // Byte store then load
    cyc(); drive(1'b0, 1'b1, 4'b1111, 32'h0000_0100, 32'h0000_0000); settle();
    check("preload_stall", {31'd0, dmem_stall}, 32'd0);
    cyc(); drive(1'b0, 1'b1, 4'b0100, 32'h0000_0102, 32'h00AB_0000); settle();
    check("bytewr_stall", {31'd0, dmem_stall}, 32'd0);
    check("bytewr_bus_err", {31'd0, bus_err}, 32'd0);
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h0000_0100, 32'd0); settle();
    check("byterd_stall", {31'd0, dmem_stall}, 32'd1);
    check("byterd_rdata_req", dmem_r_data, 32'd0);
    cyc(); settle();
    check("byterd_resp_stall", {31'd0, dmem_stall}, 32'd0);
    check("byterd_resp_rdata", dmem_r_data, 32'h00AB_0000);
    cyc(); idle(); settle();
    check("after_rd_rdata", dmem_r_data, 32'd0);

    // Word store and aliased load
    cyc(); drive(1'b0, 1'b1, 4'b1111, 32'h0000_0010, 32'h1234_5678); settle();
    check("wordwr_stall", {31'd0, dmem_stall}, 32'd0);
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h0001_0010, 32'd0); settle();
    check("alias_stall", {31'd0, dmem_stall}, 32'd1);
    cyc(); settle();
    check("alias_rdata", dmem_r_data, 32'h1234_5678);
    check("alias_resp_stall", {31'd0, dmem_stall}, 32'd0);
    cyc(); idle();

    // Read+write together is a write
    cyc(); drive(1'b1, 1'b1, 4'b1111, 32'h0000_0030, 32'hA5A5_A5A5); settle();
    check("rw_stall", {31'd0, dmem_stall}, 32'd0);
    check("rw_rdata", dmem_r_data, 32'd0);
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h0000_0030, 32'd0); settle();
    check("rw_rd_stall", {31'd0, dmem_stall}, 32'd1);
    cyc(); settle();
    check("rw_rd_rdata", dmem_r_data, 32'hA5A5_A5A5);
    cyc(); idle();

    // Stray ack while idle is ignored
    cyc(); mmio_ack = 1'b1; mmio_r_data = 32'h7777_7777; settle();
    check("stray_ack_stall", {31'd0, dmem_stall}, 32'd0);
    check("stray_ack_req", {31'd0, mmio_req}, 32'd0);
    cyc(); mmio_ack = 1'b0; settle();
    check("stray_ack_rdata", dmem_r_data, 32'd0);

    // MMIO read, ack on the second request cycle
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h1100_0004, 32'd0); settle();
    check("mrd_req_stall", {31'd0, dmem_stall}, 32'd1);
    check("mrd_req_c0", {31'd0, mmio_req}, 32'd0);
    cyc(); settle();
    check("mrd_req_c1", {31'd0, mmio_req}, 32'd1);
    check("mrd_addr", mmio_addr, 32'h1100_0004);
    check("mrd_we", {31'd0, mmio_we}, 32'd0);
    check("mrd_wait_stall", {31'd0, dmem_stall}, 32'd1);
    cyc(); mmio_ack = 1'b1; mmio_r_data = 32'hCAFE_F00D; settle();
    check("mrd_req_c2", {31'd0, mmio_req}, 32'd1);
    check("mrd_ack_stall", {31'd0, dmem_stall}, 32'd1);
    cyc(); mmio_ack = 1'b0; mmio_r_data = 32'd0; settle();
    check("mrd_done_req", {31'd0, mmio_req}, 32'd0);
    check("mrd_done_stall", {31'd0, dmem_stall}, 32'd0);
    check("mrd_done_rdata", dmem_r_data, 32'hCAFE_F00D);
    check("mrd_done_bus_err", {31'd0, bus_err}, 32'd0);
    cyc(); idle(); settle();
    check("mrd_after_rdata", dmem_r_data, 32'd0);

    // MMIO write timeout
    cyc(); drive(1'b0, 1'b1, 4'b1111, 32'h1100_0000, 32'h55AA_55AA); settle();
    check("mto_req_stall", {31'd0, dmem_stall}, 32'd1);
    cyc(); settle();
    check("mto_we", {31'd0, mmio_we}, 32'd1);
    check("mto_strb", {28'd0, mmio_strb}, 32'h0000_000F);
    check("mto_wdata", mmio_w_data, 32'h55AA_55AA);
    n = 0;
    while (mmio_req === 1'b1 && n < 40) begin
      n++;
      cyc(); settle();
    end
    check("mto_req_cycles", n, 32'd16);
    check("mto_done_stall", {31'd0, dmem_stall}, 32'd0);
    check("mto_done_bus_err", {31'd0, bus_err}, 32'd1);
    check("mto_done_rdata", dmem_r_data, 32'd0);
    cyc(); idle(); settle();
    check("mto_bus_err_pulse", {31'd0, bus_err}, 32'd0);

    // Ack on the cycle the timeout would expire: ack wins
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h1100_0008, 32'd0); settle();
    check("mlate_req_stall", {31'd0, dmem_stall}, 32'd1);
    for (int i = 0; i < 15; i++) cyc();
    cyc(); mmio_ack = 1'b1; mmio_r_data = 32'h0BAD_F00D; settle();
    check("mlate_req_c16", {31'd0, mmio_req}, 32'd1);
    cyc(); mmio_ack = 1'b0; mmio_r_data = 32'd0; settle();
    check("mlate_done_req", {31'd0, mmio_req}, 32'd0);
    check("mlate_bus_err", {31'd0, bus_err}, 32'd0);
    check("mlate_rdata", dmem_r_data, 32'h0BAD_F00D);
    check("mlate_stall", {31'd0, dmem_stall}, 32'd0);
    cyc(); idle();

    // Reset in the middle of an MMIO wait
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h1100_0000, 32'd0);
    cyc(); cyc(); cyc(); settle();
    check("mrst_pre_req", {31'd0, mmio_req}, 32'd1);
    rst = 1'b0; settle();
    check("mrst_req", {31'd0, mmio_req}, 32'd0);
    check("mrst_stall", {31'd0, dmem_stall}, 32'd0);
    check("mrst_bus_err", {31'd0, bus_err}, 32'd0);
    cyc(); idle();
    cyc(); rst = 1'b1;
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h0000_0010, 32'd0); settle();
    check("mrst_rd_stall", {31'd0, dmem_stall}, 32'd1);
    check("mrst_rd_req", {31'd0, mmio_req}, 32'd0);
    cyc(); settle();
    check("mrst_rd_rdata", dmem_r_data, 32'h1234_5678);
    cyc(); idle();

    // Odd strobe shapes
    cyc(); drive(1'b0, 1'b1, 4'b1111, 32'h0000_0020, 32'h1122_3344);
    cyc(); drive(1'b0, 1'b1, 4'b0110, 32'h0000_0020, 32'hAABB_CCDD); settle();
    check("strb0110_stall", {31'd0, dmem_stall}, 32'd0);
    check("strb0110_bus_err", {31'd0, bus_err}, {31'd0, EXP_STRB_ERR});
    cyc(); drive(1'b0, 1'b1, 4'b0000, 32'h0000_0020, 32'hFFFF_FFFF); settle();
    check("strb0000_stall", {31'd0, dmem_stall}, 32'd0);
    check("strb0000_bus_err", {31'd0, bus_err}, {31'd0, EXP_STRB_ERR});
    cyc(); drive(1'b1, 1'b0, 4'b0000, 32'h0000_0020, 32'd0); settle();
    check("strb_rd_stall", {31'd0, dmem_stall}, 32'd1);
    cyc(); settle();
    check("strb_rd_rdata", dmem_r_data, EXP_WORD20);
    cyc(); idle(); settle();
    check("strb_after_bus_err", {31'd0, bus_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_dmem_ctrl.md
Name: otter_dmem_ctrl

Overview:
- Responder end of the core's data-memory port; it answers dmem_r_en, dmem_w_en, dmem_w_strb, dmem_addr and dmem_w_data, and returns dmem_r_data.
- Backs a byte-strobed synchronous RAM.
- Bridges an MMIO address window onto a req/ack peripheral bus.
- Drives dmem_stall so the core holds its request (gates pc_w_en) until the access completes.

Parameters:
- ADDR_WIDTH, 14, RAM word-address bits (2^14 words = 64 KiB).
- MMIO_BASE, 32'h1100_0000, base of the MMIO window.
- MMIO_MASK, 32'hFF00_0000, address bits compared against MMIO_BASE.
- TIMEOUT, 16, MMIO wait cycles before the bus-error abort (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- dmem_r_en  in  1  read request.
- dmem_w_en  in  1  write request.
- dmem_w_strb  in  4  byte-lane write enables, already lane-shifted by the core.
- dmem_addr  in  32  byte address.
- dmem_w_data  in  32  write data, lane-aligned.
- dmem_r_data  out  32  read data, valid in the response cycle.
- dmem_stall  out  1  core must hold its request while high.
- bus_err  out  1  one-cycle pulse on an aborted access.
- mmio_req  out  1  peripheral request, held until ack.
- mmio_we  out  1  peripheral write.
- mmio_strb  out  4  peripheral byte enables.
- mmio_addr  out  32  peripheral address.
- mmio_w_data  out  32  peripheral write data.
- mmio_ack  in  1  peripheral completion, one-cycle pulse.
- mmio_r_data  in  32  peripheral read data, valid with mmio_ack.

Behaviour:
- Reset (rst=0, async): state=IDLE; timeout counter=0; all outputs 0. RAM contents are not cleared. Reset asserted mid-access drops the access; no mmio_req survives reset.
- Region decode: MMIO if (dmem_addr & MMIO_MASK)==MMIO_BASE, else RAM.
- RAM indexing: word index dmem_addr[ADDR_WIDTH+1:2]; higher address bits are ignored, so addresses alias and wrap.
- Priority: if dmem_r_en and dmem_w_en are both high, the access is a write and dmem_r_data=0.
- dmem_r_data is 0 outside a read response cycle.

State machine (IDLE, RAM_RD, MMIO_WAIT, DONE):
- IDLE, RAM write: byte lanes are written at the clock edge; dmem_stall=0; zero-stall write; stay IDLE. A strobe of 4'b0000 writes nothing.
- IDLE, RAM read: dmem_stall=1 (combinational); go to RAM_RD.
- RAM_RD: dmem_stall=0; dmem_r_data = RAM word, one-cycle latency; go to IDLE. The held request is not re-accepted.
- IDLE, MMIO access: dmem_stall=1; register mmio_addr, mmio_we, mmio_strb and mmio_w_data; assert mmio_req from the next cycle; go to MMIO_WAIT.
- MMIO_WAIT: dmem_stall=1; mmio_req=1; the counter increments every cycle.
  - mmio_ack seen: capture mmio_r_data, clear the counter, drop mmio_req in the same edge, go to DONE.
  - Counter reaches TIMEOUT with no ack: drop mmio_req, latch read data 32'hDEAD_BEEF, pulse bus_err, go to DONE.
  - ack arriving on the same cycle the timeout expires: ack wins, no bus_err.
- DONE: dmem_stall=0; dmem_r_data = captured data for reads, 0 for writes; go to IDLE.
- mmio_ack outside MMIO_WAIT is ignored.
- MMIO latency: minimum 3 cycles from request to release (request cycle, one wait cycle with ack, DONE).

Optional Feature:
- Macro: OTTER_DMEM_STRB_CHK_EN.
- When defined, the legal write strobes are 0001, 0010, 0100, 1000, 0011, 1100 and 1111. Each must also match dmem_addr[1:0]: the lowest set strobe bit equals addr[1:0], and 0011/1100 require an even address.
- A violating write is dropped for both RAM and MMIO, pulses bus_err in the request cycle, and causes no stall.
- When undefined, any strobe pattern is written as given and bus_err comes only from MMIO timeout.

Decomposition:
- Package otter_dmem_pkg holds:
  - the state encoding (IDLE, RAM_RD, MMIO_WAIT, DONE);
  - the MMIO_BASE and MMIO_MASK defaults;
  - BUS_ERR_DATA=32'hDEAD_BEEF;
  - the legal strobe constants.
- Sub-module otter_dmem_ram: single-port synchronous RAM with 4 byte-write enables and registered read, parameterised by ADDR_WIDTH.

Test Plan:
- RAM byte store then load: write addr 0x0000_0102, strb 0100, data 0x00AB_0000, then read 0x100.
  - Read cycle: stall=1.
  - Next cycle: dmem_r_data=0x00AB_0000 (other lanes keep their prior value, 0 after preload), stall=0.
- Word store/load and aliasing: write 0x1234_5678 to 0x0000_0010, then read 0x0001_0010 (ADDR_WIDTH=14) -> 0x1234_5678 after one stall cycle.
- MMIO read: read 0x1100_0004; peripheral acks on the 2nd req cycle with 0xCAFE_F00D.
  - mmio_req high for exactly 2 cycles.
  - Then one DONE cycle with dmem_r_data=0xCAFE_F00D and stall=0.
- MMIO timeout: write 0x1100_0000, no ack -> mmio_req drops after 16 cycles, bus_err is a single pulse, stall released the following cycle.
- Reset mid-MMIO: assert rst=0 during MMIO_WAIT -> mmio_req, stall and bus_err go 0 immediately; after release the next RAM read behaves normally.
- With OTTER_DMEM_STRB_CHK_EN: write strb 0110 to 0x20 -> bus_err=1, no stall, RAM word at 0x20 unchanged on readback.
